dmem_arbiter: RTL
=================

# dmem_arbiter

Two-requester arbiter sharing the single data-memory port between the pipelined CPU's MEM stage and a DMA/loader engine. Sits between the CPU memory bus (memory-range accesses only; device accesses bypass it) and DataMemory. The CPU owns the port by default; the DMA gets bounded bursts, with a starvation timer that forces a DMA grant. A CPU access that cannot be served raises `cpu_stall`, which freezes the whole pipeline.

## Interface
- `MAX_WAIT`, 8: cycles a pending DMA request may be refused before the grant is forced (≥1).
- `BURST`, 4: maximum DMA beats per grant (≥1).

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `cpu_read`  in  1  CPU memory read this cycle.
- `cpu_write`  in  1  CPU memory write this cycle.
- `cpu_address`  in  32  CPU byte address.
- `cpu_write_data`  in  32  CPU store data.
- `cpu_read_data`  out  32  load data returned to the CPU.
- `cpu_stall`  out  1  CPU access not served this cycle; the pipeline must hold it.
- `dma_req`  in  1  DMA beat request; held until acked.
- `dma_write`  in  1  1 = write, 0 = read; stable while `dma_req` is high.
- `dma_address`  in  32  DMA byte address.
- `dma_write_data`  in  32  DMA store data.
- `dma_read_data`  out  32  load data returned to the DMA.
- `dma_ack`  out  1  beat completed this cycle.
- `mem_read`, `mem_write`  out  1  DataMemory strobes.
- `mem_address`  out  32  DataMemory address.
- `mem_write_data`  out  32  DataMemory write data.
- `mem_read_data`  in  32  DataMemory combinational read data.

## Operation
- States: CPU_OWN (reset state) and DMA_OWN. Registered state, `wait_cnt`, `burst_cnt`.
- `cpu_acc` = `cpu_read` | `cpu_write`.

**CPU_OWN**
- The mem port is driven by the CPU signals.
- Outputs: `cpu_stall` = 0, `dma_ack` = 0.
- `wait_cnt` increments (saturating at `MAX_WAIT`) each cycle `dma_req` is high and is cleared when `dma_req` is low.
- Next state is DMA_OWN when `dma_req` & (!`cpu_acc` | `wait_cnt` ≥ `MAX_WAIT`). The current-cycle CPU access still completes.
- On entry to DMA_OWN: `burst_cnt` ← 0, `wait_cnt` ← 0.

**DMA_OWN**
- The mem port is driven by the DMA signals, gated by `dma_req`.
- `dma_ack` = `dma_req`; `cpu_stall` = `cpu_acc`.
- Each acked beat increments `burst_cnt`.
- Return to CPU_OWN after the cycle in which either:
  - `dma_req` is low (no beat that cycle), or
  - the acked beat is number `BURST` (`burst_cnt` == `BURST`-1).

**Data and decoding**
- `cpu_read_data` = `dma_read_data` = `mem_read_data` (both are valid only on their served cycle).
- `mem_read` / `mem_write` are never asserted for a requester that is not served.
- Simultaneous `cpu_read` & `cpu_write`: write takes precedence, and both strobes are passed as given. DataMemory defines the behaviour; this is not an error case.
- The `MAX_WAIT` guarantee: a DMA request waits at most `MAX_WAIT`+1 cycles before its first beat.

## Timing
- Served accesses have zero added latency: a combinational read in the same cycle, and a write committed at the next `clk` edge by DataMemory.
- A CPU→DMA handover costs 0 cycles of CPU stall. The first DMA beat happens in the first DMA_OWN cycle.
- A DMA→CPU handover costs one cycle, the transition cycle itself, only when `dma_req` dropped. Burst-limit exits cost none.
- While `reset` is high:
  - At the next edge: state ← CPU_OWN, counters ← 0.
  - Combinationally: `mem_write` = 0, `mem_read` = 0, `dma_ack` = 0, `cpu_stall` = 0.
- Reset mid-burst aborts the burst. Unacked beats are not performed, and the DMA must re-present them.
- After reset, outputs follow the CPU_OWN rules.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum (CPU_OWN, DMA_OWN);
  - the default `MAX_WAIT`/`BURST` constants;
  - the counter-width function (`$clog2(MAX_WAIT+1)`, `$clog2(BURST)`).
- No sub-module: a single module with one registered FSM and a combinational port mux.

## Test plan
- CPU only: `cpu_write` to 0x10 with 0xDEADBEEF, then `cpu_read` of 0x10 → read returns 0xDEADBEEF; `cpu_stall` stays 0 throughout.
- DMA into an idle CPU: `dma_req` held for 6 read beats at 0x0,0x4,… →
  - acks on beats 1–4 in consecutive cycles;
  - a re-grant, then beats 5–6 acked;
  - `cpu_stall` never asserted.
- Starvation: `cpu_read` held every cycle, `dma_req` raised at cycle 0 → first `dma_ack` at cycle `MAX_WAIT`+1 = 9, with `cpu_stall` = 1 for exactly `BURST` = 4 cycles.
- Simultaneous request with the CPU idle on that cycle: `dma_req` and `cpu_write` rise together one cycle later → the CPU write completes in CPU_OWN and the DMA is granted the next cycle.
- Early release: `dma_req` drops after 2 acked beats → DMA_OWN is held 3 cycles, `cpu_stall` is high during the no-beat cycle if the CPU is requesting, and CPU_OWN follows.
- Reset mid-burst: `reset` asserted after beat 2 with `dma_req` high → no `dma_ack` or `mem_write` in the reset cycle; afterwards the state is CPU_OWN with `wait_cnt` = 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and sizing helpers for the data-memory port arbiter.
package dmem_arb_pkg;

   typedef enum logic {
      CPU_OWN = 1'b0,
      DMA_OWN = 1'b1
   } arb_state_e;

   localparam int unsigned DEF_MAX_WAIT = 8;
   localparam int unsigned DEF_BURST    = 4;

   function automatic int unsigned wait_cnt_w(input int unsigned max_wait);
      return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
   endfunction

   // A one-beat burst still needs a 1-bit counter to keep the vector legal.
   function automatic int unsigned burst_cnt_w(input int unsigned burst);
      return (burst <= 1) ? 1 : $clog2(burst);
   endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter for the single DataMemory port; zero added latency on served accesses.
// CPU owns the port by default, DMA gets bounded bursts; refused CPU accesses raise cpu_stall.
import dmem_arb_pkg::*;

module dmem_arbiter #(
   parameter int unsigned MAX_WAIT = DEF_MAX_WAIT,
   parameter int unsigned BURST    = DEF_BURST
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_read,
   input  logic        cpu_write,
   input  logic [31:0] cpu_address,
   input  logic [31:0] cpu_write_data,
   output logic [31:0] cpu_read_data,
   output logic        cpu_stall,
   input  logic        dma_req,
   input  logic        dma_write,
   input  logic [31:0] dma_address,
   input  logic [31:0] dma_write_data,
   output logic [31:0] dma_read_data,
   output logic        dma_ack,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   localparam int unsigned WW = wait_cnt_w(MAX_WAIT);
   localparam int unsigned BW = burst_cnt_w(BURST);
   localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);
   localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);

   arb_state_e    state_q, state_d;
   logic [WW-1:0] wait_cnt_q, wait_cnt_d;
   logic [BW-1:0] burst_cnt_q, burst_cnt_d;
   logic          cpu_acc;

   assign cpu_acc = cpu_read | cpu_write;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= CPU_OWN;
         wait_cnt_q  <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      burst_cnt_d = burst_cnt_q;
      case (state_q)
         CPU_OWN: begin
            if (!dma_req)
               wait_cnt_d = '0;
            else if (wait_cnt_q < WAIT_LIMIT)
               wait_cnt_d = wait_cnt_q + 1'b1;
            // The current CPU access still completes; the handover takes effect next cycle.
            if (dma_req && (!cpu_acc || wait_cnt_q >= WAIT_LIMIT)) begin
               state_d     = DMA_OWN;
               wait_cnt_d  = '0;
               burst_cnt_d = '0;
            end
         end
         DMA_OWN: begin
            wait_cnt_d = '0;
            if (dma_req)
               burst_cnt_d = burst_cnt_q + 1'b1;
            if (!dma_req || burst_cnt_q == BURST_LAST)
               state_d = CPU_OWN;
         end
         default: state_d = CPU_OWN;
      endcase
   end

   always_comb begin
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_address    = cpu_address;
      mem_write_data = cpu_write_data;
      dma_ack        = 1'b0;
      cpu_stall      = 1'b0;
      case (state_q)
         CPU_OWN: begin
            mem_read  = cpu_read;
            mem_write = cpu_write;
         end
         DMA_OWN: begin
            mem_read       = dma_req & ~dma_write;
            mem_write      = dma_req & dma_write;
            mem_address    = dma_address;
            mem_write_data = dma_write_data;
            dma_ack        = dma_req;
            cpu_stall      = cpu_acc;
         end
         default: ;
      endcase
      // Reset aborts any in-flight beat so nothing commits during the reset cycle.
      if (reset) begin
         mem_read  = 1'b0;
         mem_write = 1'b0;
         dma_ack   = 1'b0;
         cpu_stall = 1'b0;
      end
   end

   assign cpu_read_data = mem_read_data;
   assign dma_read_data = mem_read_data;

endmodule
